serial_tx: RTL and testbench
============================

# serial_tx

Parallel-in, serial-out transmitter that drives the serial data line captured by the team's serial-in shift register. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock. A frame strobe and an end-of-word pulse accompany the bits. Back-to-back words stream with no idle gap, so a downstream shift register holds each complete word exactly WIDTH clocks after its first bit.

## Interface
- WIDTH, 4: word length in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1: 1 sends data[WIDTH-1] first, matching a left-shifting receiver; 0 sends data[0] first.

- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- data  input  WIDTH  word to transmit; sampled only on an accepting edge.
- valid  input  1  word on data is offered.
- ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  serial data bit.
- frame  output  1  high while sout carries a valid data bit.
- done  output  1  one-cycle pulse while the last bit of a word is on sout.

## Operation
- States:
  - IDLE: no word in flight.
  - SHIFT: a word is being sent. A bit counter runs from 0 to WIDTH-1; its width is clog2(WIDTH).
- Ready rule:
  - ready = (state == IDLE) or (state == SHIFT and count == WIDTH-1).
  - ready is combinational from state only and never depends on valid.
- Accept: a rising edge with valid & ready. On that edge the block:
  - loads the shift register with data;
  - drives sout to the first bit;
  - sets frame = 1 and count = 0;
  - enters SHIFT.
- SHIFT with count < WIDTH-1: each edge shifts, puts the next bit on sout, and increments count.
- Last bit (count == WIDTH-1):
  - done = 1 for exactly this cycle.
  - On the next edge, if valid is high, the new word is accepted with no gap and frame stays 1.
  - If valid is low, the block enters IDLE with sout = 0, frame = 0, done = 0.
- valid while busy (ready = 0): ignored. data is not sampled, and the word is lost unless the source holds valid.
- data may change freely except on an accepting edge.
- All outputs except ready are registered.

## Timing
- Reset values (asynchronous, immediate on reset_n falling): state = IDLE, count = 0, shift register = 0, sout = 0, frame = 0, done = 0, ready = 1.
- Reset release: the first accept can occur on the first rising edge with reset_n high.
- Latency: for a word accepted on edge k, bit i (i = 0..WIDTH-1) is on sout in the cycle after edge k+i.
- frame is high for cycles k+1 .. k+WIDTH.
- done is high in cycle k+WIDTH only.
- ready is low for cycles k+1 .. k+WIDTH-1.
- Throughput: one word per WIDTH clocks when valid is held continuously.
- Reset mid-frame:
  - The word is aborted and outputs go to their reset values without waiting for clk.
  - No partial done pulse is produced.
  - The word is not resumed after reset.
- Receiver alignment: a left-shifting serial-in register sampling sout on the same clk edges holds the full word after the WIDTH-th edge following the accept (MSB_FIRST = 1).

## Test plan
- Reset: hold reset_n = 0 with clk toggling and valid = 1 -> sout = 0, frame = 0, done = 0, ready = 1 throughout; no word accepted.
- Single word: WIDTH = 4, data = 4'b1101, valid pulsed for one accepting edge -> sout = 1,1,0,1 on the next four cycles; frame high for exactly 4 cycles; done high only on the 4th; ready low on cycles 1-3; then sout = 0.
- Back-to-back: 4'b1101 then 4'b0001, with valid held and data switched at the last-bit cycle -> 8 contiguous bits 1,1,0,1,0,0,0,1; frame high for 8 cycles; done on cycles 4 and 8.
- Busy rejection: during bits 1-3 of 4'b1101, present valid = 1 with data = 4'b1010, then drop valid before the last-bit cycle -> only 1101 is sent; 1010 never appears on sout.
- Reset mid-frame: assert reset_n = 0 between edges after 2 bits of 4'b1011 -> sout and frame go to 0 immediately and ready = 1. Release, then send 4'b0110 -> 0,1,1,0 is sent cleanly with one done pulse.
- LSB-first and loopback:
  - MSB_FIRST = 0, data = 4'b1101 -> sout = 1,0,1,1.
  - MSB_FIRST = 1 feeding a 4-bit left-shifting shift register -> q = 4'b1101 exactly 4 edges after the accept.

Source files
------------

// File: rtl/serial_tx_if.sv
// Word handshake plus serial line bundle for serial_tx.
// The slave side is the transmitter; the master side is the word source and line observer.
interface serial_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             sout;
    logic             frame;
    logic             done;

    modport master (
        output data, valid,
        input  ready, sout, frame, done
    );

    modport slave (
        input  data, valid,
        output ready, sout, frame, done
    );
endinterface

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: one WIDTH-bit word per WIDTH clocks,
// with a frame strobe and an end-of-word pulse; back-to-back words stream without a gap.
module serial_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    serial_tx_if.slave bus
);
    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             sout, sout_nxt;
    logic             frame, frame_nxt;
    logic             done, done_nxt;
    logic             ready;
    logic             accept;

    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready opens on the last-bit cycle so the next word follows with no idle gap.
    assign ready  = (state == IDLE) || ((state == SHIFT) && (count == LAST));
    assign accept = bus.valid && ready;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_nxt = state;
        count_nxt = count;
        shreg_nxt = shreg;
        sout_nxt  = sout;
        frame_nxt = frame;

        if (accept) begin
            state_nxt = SHIFT;
            count_nxt = '0;
            shreg_nxt = bus.data;
            sout_nxt  = lead_bit(bus.data);
            frame_nxt = 1'b1;
        end else if (state == SHIFT) begin
            if (count != LAST) begin
                count_nxt = count + 1'b1;
                shreg_nxt = advance(shreg);
                sout_nxt  = lead_bit(shreg_nxt);
            end else begin
                state_nxt = IDLE;
                count_nxt = '0;
                shreg_nxt = '0;
                sout_nxt  = 1'b0;
                frame_nxt = 1'b0;
            end
        end

        // done is registered so it lines up with the last bit on sout.
        done_nxt = (state_nxt == SHIFT) && (count_nxt == LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            shreg <= '0;
            sout  <= 1'b0;
            frame <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            shreg <= shreg_nxt;
            sout  <= sout_nxt;
            frame <= frame_nxt;
            done  <= done_nxt;
        end
    end

    assign bus.ready = ready;
    assign bus.sout  = sout;
    assign bus.frame = frame;
    assign bus.done  = done;
endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: an MSB-first and an LSB-first instance share one
// stimulus; a per-cycle schedule model plus directed literal checks judge both.
module tb_serial_tx;
    localparam int W = 4;
    localparam int N = 256;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] data_r;
    logic         valid_r;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected line state per cycle index (cycle c follows edge c).
    bit exp_sout_m [0:N-1];
    bit exp_sout_l [0:N-1];
    bit exp_frame  [0:N-1];
    bit exp_done   [0:N-1];
    bit exp_busy   [0:N-1];

    // Bits observed while frame is high, in arrival order.
    bit hist_m [0:N-1];
    bit hist_l [0:N-1];
    int nbits      = 0;
    int done_total = 0;

    logic [W-1:0] rx_q = '0;

    serial_tx_if #(.WIDTH(W)) bus_m ();
    serial_tx_if #(.WIDTH(W)) bus_l ();

    assign bus_m.data  = data_r;
    assign bus_m.valid = valid_r;
    assign bus_l.data  = data_r;
    assign bus_l.valid = valid_r;

    serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_m (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_m)
    );

    serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_l (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_l)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pack_m(input int start, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w = {w[30:0], hist_m[start + i]};
        return w;
    endfunction

    function automatic logic [31:0] pack_l(input int start, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w = {w[30:0], hist_l[start + i]};
        return w;
    endfunction

    // Model: an accept on edge e puts bit i on the line in cycle e+i, busy for the first
    // W-1 of those cycles, done on the last; reset wipes every scheduled cycle.
    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            for (int i = cyc + 1; i < N; i++) begin
                exp_sout_m[i] = 1'b0;
                exp_sout_l[i] = 1'b0;
                exp_frame[i]  = 1'b0;
                exp_done[i]   = 1'b0;
                exp_busy[i]   = 1'b0;
            end
        end else if (valid_r && !exp_busy[cyc]) begin
            for (int i = 0; i < W; i++) begin
                if (cyc + 1 + i < N) begin
                    exp_sout_m[cyc + 1 + i] = data_r[W - 1 - i];
                    exp_sout_l[cyc + 1 + i] = data_r[i];
                    exp_frame[cyc + 1 + i]  = 1'b1;
                    exp_busy[cyc + 1 + i]   = (i < W - 1);
                    exp_done[cyc + 1 + i]   = (i == W - 1);
                end
            end
        end
        cyc = cyc + 1;
    end

    // Left-shifting receiver on the MSB-first line.
    initial forever begin
        @(posedge clk);
        rx_q = {rx_q[W-2:0], bus_m.sout};
    end

    initial forever begin
        @(negedge clk);
        if (bus_m.frame) begin
            hist_m[nbits] = bus_m.sout;
            hist_l[nbits] = bus_l.sout;
            nbits = nbits + 1;
        end
        if (bus_m.done) done_total = done_total + 1;
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            check("rst_sout_m",  bus_m.sout,  0);
            check("rst_sout_l",  bus_l.sout,  0);
            check("rst_frame",   bus_m.frame, 0);
            check("rst_done",    bus_m.done,  0);
            check("rst_ready_m", bus_m.ready, 1);
            check("rst_ready_l", bus_l.ready, 1);
        end else if (cyc < N) begin
            check("sout_m",  bus_m.sout,  exp_sout_m[cyc]);
            check("sout_l",  bus_l.sout,  exp_sout_l[cyc]);
            check("frame_m", bus_m.frame, exp_frame[cyc]);
            check("frame_l", bus_l.frame, exp_frame[cyc]);
            check("done_m",  bus_m.done,  exp_done[cyc]);
            check("done_l",  bus_l.done,  exp_done[cyc]);
            check("ready_m", bus_m.ready, !exp_busy[cyc]);
            check("ready_l", bus_l.ready, !exp_busy[cyc]);
        end
    end

    initial begin
        int s;
        int d0;

        // Reset held with valid offered: nothing may be accepted.
        reset_n = 1'b0;
        valid_r = 1'b1;
        data_r  = 4'hF;
        step(4);
        check("reset_no_bits", nbits, 0);
        valid_r = 1'b0;
        reset_n = 1'b1;
        step(2);
        check("idle_after_reset", bus_m.frame, 0);

        // Single word, with receiver loopback.
        s = nbits; d0 = done_total;
        data_r  = 4'b1101;
        valid_r = 1'b1;
        step(1);
        valid_r = 1'b0;
        step(4);
        check("loopback_q", rx_q, 4'b1101);
        step(2);
        check("single_nbits", nbits - s, 4);
        check("single_msb", pack_m(s, 4), 4'b1101);
        check("single_lsb", pack_l(s, 4), 4'b1011);
        check("single_done", done_total - d0, 1);

        // Back-to-back words with valid held.
        s = nbits; d0 = done_total;
        data_r  = 4'b1101;
        valid_r = 1'b1;
        step(1);
        step(3);
        data_r = 4'b0001;
        step(1);
        valid_r = 1'b0;
        step(6);
        check("b2b_nbits", nbits - s, 8);
        check("b2b_msb", pack_m(s, 8), 8'b1101_0001);
        check("b2b_lsb", pack_l(s, 8), 8'b1011_1000);
        check("b2b_done", done_total - d0, 2);

        // Busy rejection: a second word offered only while ready is low.
        s = nbits; d0 = done_total;
        data_r  = 4'b1101;
        valid_r = 1'b1;
        step(1);
        data_r = 4'b1010;
        step(3);
        valid_r = 1'b0;
        step(5);
        check("busy_nbits", nbits - s, 4);
        check("busy_msb", pack_m(s, 4), 4'b1101);
        check("busy_done", done_total - d0, 1);

        // Reset mid-frame after two bits, then a clean word.
        d0 = done_total;
        data_r  = 4'b1011;
        valid_r = 1'b1;
        step(1);
        valid_r = 1'b0;
        step(1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_sout_m", bus_m.sout, 0);
        check("midrst_sout_l", bus_l.sout, 0);
        check("midrst_frame", bus_m.frame, 0);
        check("midrst_done", bus_m.done, 0);
        check("midrst_ready", bus_m.ready, 1);
        step(2);
        check("midrst_no_done", done_total - d0, 0);
        s = nbits; d0 = done_total;
        reset_n = 1'b1;
        data_r  = 4'b0110;
        valid_r = 1'b1;
        step(1);
        valid_r = 1'b0;
        step(6);
        check("post_nbits", nbits - s, 4);
        check("post_msb", pack_m(s, 4), 4'b0110);
        check("post_lsb", pack_l(s, 4), 4'b0110);
        check("post_done", done_total - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
